alu_arbiter: RTL

- Shares one 32-bit ALU instance between two requesters (e.g. execute stage and a debug/CSR unit) using valid/ready request and response channels.
- Grants one requester at a time (round-robin, or fixed priority by parameter) and registers its operands onto the ALU input port.
- Captures the ALU result and returns it to the granted requester.
- Sits between the requesters and the combinational ALU; `alu_op` codes pass through unmodified using the riscv_alu_constants encoding.

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels of both requesters plus the shared ALU port
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_op1;
   logic [WIDTH-1:0] req0_op2;
   logic [3:0]       req0_aluop;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_result;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_op1;
   logic [WIDTH-1:0] req1_op2;
   logic [3:0]       req1_aluop;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_result;
   logic [WIDTH-1:0] alu_op1;
   logic [WIDTH-1:0] alu_op2;
   logic [3:0]       alu_aluop;
   logic [WIDTH-1:0] alu_result;
   logic             busy;
   modport slave (
      input  req0_valid, req0_op1, req0_op2, req0_aluop, rsp0_ready,
      input  req1_valid, req1_op1, req1_op2, req1_aluop, rsp1_ready,
      input  alu_result,
      output req0_ready, rsp0_valid, rsp0_result,
      output req1_ready, rsp1_valid, rsp1_result,
      output alu_op1, alu_op2, alu_aluop, busy
   );
   modport master (
      output req0_valid, req0_op1, req0_op2, req0_aluop, rsp0_ready,
      output req1_valid, req1_op1, req1_op2, req1_aluop, rsp1_ready,
      output alu_result,
      input  req0_ready, rsp0_valid, rsp0_result,
      input  req1_ready, rsp1_valid, rsp1_result,
      input  alu_op1, alu_op2, alu_aluop, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters
module alu_arbiter #(
   parameter int WIDTH       = 32,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] op1_q, op1_d;
   logic [WIDTH-1:0] op2_q, op2_d;
   logic [3:0]       aluop_q, aluop_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic             any_req, gnt, own_ready;
   // grant: a lone requester wins; on a tie round-robin skips the last owner, fixed priority picks 0
   always_comb begin
      any_req   = bus.req0_valid | bus.req1_valid;
      gnt       = (bus.req0_valid && bus.req1_valid) ? (ROUND_ROBIN ? ~last_q : 1'b0) : bus.req1_valid;
      own_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
   end
   assign bus.req0_ready  = (state_q == IDLE) && any_req && !gnt;
   assign bus.req1_ready  = (state_q == IDLE) && any_req && gnt;
   assign bus.rsp0_valid  = rsp_valid_q[0];
   assign bus.rsp1_valid  = rsp_valid_q[1];
   assign bus.rsp0_result = result_q;
   assign bus.rsp1_result = result_q;
   assign bus.alu_op1     = op1_q;
   assign bus.alu_op2     = op2_q;
   assign bus.alu_aluop   = aluop_q;
   assign bus.busy        = state_q != IDLE;
   // accept in IDLE, capture the ALU in EXEC, hold the response until the owner takes it
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      aluop_d     = aluop_q;
      result_d    = result_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: if (any_req) begin
            state_d = EXEC;
            owner_d = gnt;
            op1_d   = gnt ? bus.req1_op1 : bus.req0_op1;
            op2_d   = gnt ? bus.req1_op2 : bus.req0_op2;
            aluop_d = gnt ? bus.req1_aluop : bus.req0_aluop;
         end
         EXEC: begin
            state_d     = RESP;
            result_d    = bus.alu_result;
            rsp_valid_d = owner_q ? 2'b10 : 2'b01;
         end
         RESP: if (own_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 2'b00;
            last_d      = owner_q;
         end
         default: state_d = IDLE;
      endcase
   end
   // all state in one register bank; reset drops any in-flight operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         op1_q       <= '0;
         op2_q       <= '0;
         aluop_q     <= '0;
         result_q    <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         aluop_q     <= aluop_d;
         result_q    <= result_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end
endmodule
